vlan_tag_inserter: RTL and testbench
====================================

Name: vlan_tag_inserter

Overview:
- Egress counterpart of the NMU VLAN parser: inserts an 802.1Q C-tag (TPID 0x8100 plus a 16-bit TCI) after the 12-byte MAC header of outgoing Ethernet frames on an AXI stream.
- The TCI and the per-packet enable are looked up per source tid through a config-select/config-reg pair.
- Sits between the per-tid egress arbiter and the MAC TX path in the full NMU.
- Untagged-configured tids pass through unmodified.

Parameters:
AXIS_BUS_WIDTH, 64, data width; only 64 supported, any other value is an elaboration error
AXIS_ID_WIDTH, 4, tid width; effective width max(1,AXIS_ID_WIDTH)
AXIS_DEST_WIDTH, 0, tdest width; effective width max(1,AXIS_DEST_WIDTH)

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
axis_in_tdata  in  64  frame data; byte 0 = tdata[7:0], network order
axis_in_tid  in  EFF_ID  source vNIC id
axis_in_tdest  in  EFF_DEST  destination
axis_in_tkeep  in  8  byte enables; contiguous from bit 0, all ones on non-last beats
axis_in_tlast  in  1  last beat
axis_in_tvalid  in  1  input valid
axis_in_tready  out  1  input ready
axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  as input  output stream
axis_out_tready  in  1  output ready
vlan_config_sel  out  EFF_ID  equals axis_in_tid (combinational)
vlan_config_regs  in  17  {insert_en, tci[15:0]} for the selected tid
tagged_pkt_count  out  32  packets tagged since reset; saturates at 0xFFFFFFFF

Behaviour:
- Output stream fully registered. Latency is 1 cycle from an accepted input beat to axis_out_tvalid.
- axis_in_tready = (!axis_out_tvalid || axis_out_tready) && state != TAIL.
- Output beat fields are held stable while axis_out_tvalid=1 && axis_out_tready=0.
- Reset: axis_out_tvalid=0, axis_out_tlast=0, axis_out_tdata/tkeep/tid/tdest=0, tagged_pkt_count=0, carry=0, state=FIRST.
- Reset mid-packet aborts the packet. The next accepted beat is treated as a first beat.
- FIRST (beat 0):
  - Sample insert_en and tci into packet registers; forward the beat unmodified.
  - tid/tdest are latched and used for every output beat of the packet.
  - tlast on beat 0 (runt) -> forwarded unmodified, stay in FIRST.
  - Else go to HDR.
- HDR (beat 1, bytes 8-15):
  - Insert only if insert_en=1 && tkeep[3:0]==4'hF (frame >= 12 bytes). Otherwise forward this and remaining beats unmodified (PASS state, back to FIRST on tlast).
  - On insert:
    - out bytes 0-3 = in bytes 0-3; out byte 4 = 0x81, byte 5 = 0x00, byte 6 = tci[15:8], byte 7 = tci[7:0]; out tkeep = 8'hFF.
    - carry <= in bytes 4-7, carry_keep <= tkeep[7:4].
    - tagged_pkt_count increments (saturating).
  - If !tlast -> SHIFT.
  - If tlast && tkeep[4]==0 -> out tlast=1, go to FIRST.
  - If tlast && tkeep[4]==1 -> out tlast=0, go to TAIL.
- SHIFT (body):
  - out bytes 0-3 = carry; out bytes 4-7 = in bytes 0-3.
  - out tkeep = {in tkeep[3:0], 4'hF}.
  - carry <= in bytes 4-7, carry_keep <= in tkeep[7:4].
  - On tlast: if in tkeep[4]==0 -> out tlast=1, go to FIRST; else out tlast=0, go to TAIL.
- TAIL (extra beat, no input accepted):
  - out bytes 0-3 = carry, bytes 4-7 = 0; out tkeep = {4'h0, carry_keep}; tlast=1.
  - Go to FIRST when the beat is loaded into the output register.
- Output frame length = input length + 4 when tagged, unchanged otherwise.
- The config change is sampled only at FIRST, so mid-packet config changes have no effect.
- tvalid gaps on input and tready backpressure on output at any state must not corrupt carry or reorder bytes.
- No frame-level checks (FCS appended downstream). No double-tag detection.

Test Plan:
- insert_en=0, 64-byte frame tid=2 -> output identical, 8 beats, tagged_pkt_count=0.
- insert_en=1, tci=0x6005, 64-byte frame (tkeep last=0xFF) -> bytes 12-15 = 81 00 60 05, original bytes 12-63 at 16-67, 9 beats, last tkeep=0x0F, count=1.
- insert_en=1, 60-byte frame (last tkeep=0x0F) -> 64-byte output, 8 beats, last tkeep=0xFF, no TAIL beat.
- Runt cases:
  - 8-byte frame (tlast on beat 0) -> unmodified, count unchanged.
  - 10-byte frame (beat1 tkeep=0x03) -> unmodified.
  - 12-byte frame -> 16 bytes ending 81 00 TCI, tlast on beat 1.
- Random tvalid/tready toggling (50%) over 100 back-to-back frames, alternating tids with differing config -> byte-exact match to reference model, per-packet tid/tdest constant, count = number of tagged frames.
- Assert aresetn low mid-frame during SHIFT with axis_out_tready=0 -> axis_out_tvalid=0 immediately (async). The next frame after release is tagged correctly from its beat 0.

Source files
------------

// File: rtl/vlan_tag_inserter.sv
// vlan_tag_inserter: inserts an 802.1Q C-tag (0x8100 + per-tid TCI) after the
// 12-byte MAC header of frames on a 64-bit AXI stream. The output is fully
// registered, and tids configured as untagged pass through unchanged.
`timescale 1ns/1ps

module vlan_tag_inserter #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  localparam int unsigned ID_W   = (AXIS_ID_WIDTH   > 0) ? AXIS_ID_WIDTH   : 1,
  localparam int unsigned DEST_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int unsigned KEEP_W = AXIS_BUS_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [ID_W-1:0]           axis_in_tid,
  input  logic [DEST_W-1:0]         axis_in_tdest,
  input  logic [KEEP_W-1:0]         axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [ID_W-1:0]           axis_out_tid,
  output logic [DEST_W-1:0]         axis_out_tdest,
  output logic [KEEP_W-1:0]         axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [ID_W-1:0]           vlan_config_sel,
  input  logic [16:0]               vlan_config_regs,
  output logic [31:0]               tagged_pkt_count
);

  // Only the 64-bit datapath is implemented.
  if (AXIS_BUS_WIDTH != 64) begin : g_width_check
    $error("vlan_tag_inserter: only AXIS_BUS_WIDTH=64 is supported");
  end

  typedef enum logic [2:0] {
    ST_FIRST = 3'd0,
    ST_HDR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PASS  = 3'd3,
    ST_TAIL  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [AXIS_BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic [KEEP_W-1:0]         out_keep_q, out_keep_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;
  logic [ID_W-1:0]           out_tid_q, out_tid_d;
  logic [DEST_W-1:0]         out_dest_q, out_dest_d;
  logic [ID_W-1:0]           pkt_tid_q, pkt_tid_d;
  logic [DEST_W-1:0]         pkt_dest_q, pkt_dest_d;
  logic                      pkt_en_q, pkt_en_d;
  logic [15:0]               pkt_tci_q, pkt_tci_d;
  logic [31:0]               carry_q, carry_d;
  logic [3:0]                carry_keep_q, carry_keep_d;
  logic [31:0]               count_q, count_d;

  logic ld_ok_c;
  logic in_ready_c;
  logic accept_c;
  logic insert_c;

  // Handshake: output register free, and no tail beat pending.
  assign ld_ok_c    = !out_valid_q || axis_out_tready;
  assign in_ready_c = ld_ok_c && (state_q != ST_TAIL);
  assign accept_c   = axis_in_tvalid && in_ready_c;
  assign insert_c   = pkt_en_q && (axis_in_tkeep[3:0] == 4'hF);

  assign axis_in_tready   = in_ready_c;
  assign axis_out_tdata   = out_data_q;
  assign axis_out_tid     = out_tid_q;
  assign axis_out_tdest   = out_dest_q;
  assign axis_out_tkeep   = out_keep_q;
  assign axis_out_tlast   = out_last_q;
  assign axis_out_tvalid  = out_valid_q;
  assign vlan_config_sel  = axis_in_tid;
  assign tagged_pkt_count = count_q;

  // Next-state and output-register load logic.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    out_tid_d    = out_tid_q;
    out_dest_d   = out_dest_q;
    pkt_tid_d    = pkt_tid_q;
    pkt_dest_d   = pkt_dest_q;
    pkt_en_d     = pkt_en_q;
    pkt_tci_d    = pkt_tci_q;
    carry_d      = carry_q;
    carry_keep_d = carry_keep_q;
    count_d      = count_q;

    if (axis_out_tready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_FIRST: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_data_d  = axis_in_tdata;
          out_keep_d  = axis_in_tkeep;
          out_last_d  = axis_in_tlast;
          out_tid_d   = axis_in_tid;
          out_dest_d  = axis_in_tdest;
          pkt_tid_d   = axis_in_tid;
          pkt_dest_d  = axis_in_tdest;
          pkt_en_d    = vlan_config_regs[16];
          pkt_tci_d   = vlan_config_regs[15:0];
          if (!axis_in_tlast) begin
            state_d = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_tid_d   = pkt_tid_q;
          out_dest_d  = pkt_dest_q;
          if (insert_c) begin
            out_data_d   = {pkt_tci_q[7:0], pkt_tci_q[15:8], 8'h00, 8'h81,
                            axis_in_tdata[31:0]};
            out_keep_d   = 8'hFF;
            carry_d      = axis_in_tdata[63:32];
            carry_keep_d = axis_in_tkeep[7:4];
            count_d      = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
            if (!axis_in_tlast) begin
              out_last_d = 1'b0;
              state_d    = ST_SHIFT;
            end else if (!axis_in_tkeep[4]) begin
              out_last_d = 1'b1;
              state_d    = ST_FIRST;
            end else begin
              out_last_d = 1'b0;
              state_d    = ST_TAIL;
            end
          end else begin
            out_data_d = axis_in_tdata;
            out_keep_d = axis_in_tkeep;
            out_last_d = axis_in_tlast;
            state_d    = axis_in_tlast ? ST_FIRST : ST_PASS;
          end
        end
      end

      ST_SHIFT: begin
        if (accept_c) begin
          out_valid_d  = 1'b1;
          out_tid_d    = pkt_tid_q;
          out_dest_d   = pkt_dest_q;
          out_data_d   = {axis_in_tdata[31:0], carry_q};
          out_keep_d   = {axis_in_tkeep[3:0], 4'hF};
          carry_d      = axis_in_tdata[63:32];
          carry_keep_d = axis_in_tkeep[7:4];
          out_last_d   = 1'b0;
          if (axis_in_tlast) begin
            if (!axis_in_tkeep[4]) begin
              out_last_d = 1'b1;
              state_d    = ST_FIRST;
            end else begin
              state_d    = ST_TAIL;
            end
          end
        end
      end

      ST_PASS: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_tid_d   = pkt_tid_q;
          out_dest_d  = pkt_dest_q;
          out_data_d  = axis_in_tdata;
          out_keep_d  = axis_in_tkeep;
          out_last_d  = axis_in_tlast;
          if (axis_in_tlast) begin
            state_d = ST_FIRST;
          end
        end
      end

      ST_TAIL: begin
        if (ld_ok_c) begin
          out_valid_d = 1'b1;
          out_tid_d   = pkt_tid_q;
          out_dest_d  = pkt_dest_q;
          out_data_d  = {32'h0, carry_q};
          out_keep_d  = {4'h0, carry_keep_q};
          out_last_d  = 1'b1;
          state_d     = ST_FIRST;
        end
      end

      default: begin
        state_d = ST_FIRST;
      end
    endcase
  end

  // State, output and packet registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_FIRST;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_tid_q    <= '0;
      out_dest_q   <= '0;
      pkt_tid_q    <= '0;
      pkt_dest_q   <= '0;
      pkt_en_q     <= 1'b0;
      pkt_tci_q    <= '0;
      carry_q      <= '0;
      carry_keep_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      out_tid_q    <= out_tid_d;
      out_dest_q   <= out_dest_d;
      pkt_tid_q    <= pkt_tid_d;
      pkt_dest_q   <= pkt_dest_d;
      pkt_en_q     <= pkt_en_d;
      pkt_tci_q    <= pkt_tci_d;
      carry_q      <= carry_d;
      carry_keep_q <= carry_keep_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_vlan_tag_inserter.sv
// Directed bench for vlan_tag_inserter: reference frames are built in the bench
// and compared byte- and beat-exact against the captured output stream.
`timescale 1ns/1ps

module tb_vlan_tag_inserter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] axis_in_tdata;
  logic [3:0]  axis_in_tid;
  logic [0:0]  axis_in_tdest;
  logic [7:0]  axis_in_tkeep;
  logic        axis_in_tlast;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [3:0]  axis_out_tid;
  logic [0:0]  axis_out_tdest;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast;
  logic        axis_out_tvalid;
  logic        axis_out_tready;
  logic [3:0]  vlan_config_sel;
  logic [16:0] vlan_config_regs;
  logic [31:0] tagged_pkt_count;

  logic [16:0] cfg [16];

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;
  int fseed = 0;
  int exp_tagged = 0;
  int mon_frames = 0;

  logic [7:0] exp_bytes[$], mon_bytes[$];
  logic [7:0] exp_keep[$],  mon_keep[$];
  logic       exp_last[$],  mon_last[$];
  logic [3:0] exp_tid[$],   mon_tid[$];
  logic [0:0] exp_dest[$],  mon_dest[$];

  always #5 aclk = ~aclk;

  assign vlan_config_regs = cfg[vlan_config_sel];

  vlan_tag_inserter dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .axis_in_tdata    (axis_in_tdata),
    .axis_in_tid      (axis_in_tid),
    .axis_in_tdest    (axis_in_tdest),
    .axis_in_tkeep    (axis_in_tkeep),
    .axis_in_tlast    (axis_in_tlast),
    .axis_in_tvalid   (axis_in_tvalid),
    .axis_in_tready   (axis_in_tready),
    .axis_out_tdata   (axis_out_tdata),
    .axis_out_tid     (axis_out_tid),
    .axis_out_tdest   (axis_out_tdest),
    .axis_out_tkeep   (axis_out_tkeep),
    .axis_out_tlast   (axis_out_tlast),
    .axis_out_tvalid  (axis_out_tvalid),
    .axis_out_tready  (axis_out_tready),
    .vlan_config_sel  (vlan_config_sel),
    .vlan_config_regs (vlan_config_regs),
    .tagged_pkt_count (tagged_pkt_count)
  );

  // Output monitor: a beat that is valid and ready at the falling edge
  // transfers on the next rising edge.
  always @(negedge aclk) begin
    if (aresetn && axis_out_tvalid && axis_out_tready) begin
      mon_keep.push_back(axis_out_tkeep);
      mon_last.push_back(axis_out_tlast);
      mon_tid.push_back(axis_out_tid);
      mon_dest.push_back(axis_out_tdest);
      for (int i = 0; i < 8; i++) begin
        if (axis_out_tkeep[i]) mon_bytes.push_back(axis_out_tdata[8*i +: 8]);
      end
      if (axis_out_tlast) mon_frames++;
    end
  end

  // Output ready generator: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       axis_out_tready = 1'b1;
        1:       axis_out_tready = 1'($urandom_range(1));
        default: axis_out_tready = 1'b0;
      endcase
    end
  end

  task automatic clear_all();
    exp_bytes.delete(); mon_bytes.delete();
    exp_keep.delete();  mon_keep.delete();
    exp_last.delete();  mon_last.delete();
    exp_tid.delete();   mon_tid.delete();
    exp_dest.delete();  mon_dest.delete();
    mon_frames = 0;
  endtask

  function automatic int bytes_diff();
    int n;
    n = (exp_bytes.size() < mon_bytes.size()) ? exp_bytes.size() : mon_bytes.size();
    for (int i = 0; i < n; i++) if (exp_bytes[i] !== mon_bytes[i]) return i;
    if (exp_bytes.size() != mon_bytes.size()) return n;
    return -1;
  endfunction

  function automatic int beats_diff();
    int n;
    n = (exp_keep.size() < mon_keep.size()) ? exp_keep.size() : mon_keep.size();
    for (int i = 0; i < n; i++) begin
      if (exp_keep[i] !== mon_keep[i] || exp_last[i] !== mon_last[i] ||
          exp_tid[i] !== mon_tid[i] || exp_dest[i] !== mon_dest[i]) return i;
    end
    if (exp_keep.size() != mon_keep.size()) return n;
    return -1;
  endfunction

  // Drives one frame (or its first max_beats beats) and appends the expected
  // output to the reference queues. Entry/exit timing: 1 ns after a rising edge.
  task automatic send_frame(input int tid, input int dest, input int len,
                            input bit gaps, input bit flip, input int max_beats);
    logic [7:0]  b[$];
    logic [7:0]  o[$];
    logic [16:0] c;
    bit          tag;
    bit          fire;
    int          guard, nb, nob, rem;
    c = cfg[tid];
    for (int i = 0; i < len; i++) b.push_back(8'(fseed * 29 + i * 7 + 3));
    fseed++;
    tag = c[16] && (len >= 12);
    for (int i = 0; i < len; i++) begin
      if (tag && i == 12) begin
        o.push_back(8'h81); o.push_back(8'h00);
        o.push_back(c[15:8]); o.push_back(c[7:0]);
      end
      o.push_back(b[i]);
    end
    if (tag && len == 12) begin
      o.push_back(8'h81); o.push_back(8'h00);
      o.push_back(c[15:8]); o.push_back(c[7:0]);
    end
    if (tag) exp_tagged++;
    foreach (o[i]) exp_bytes.push_back(o[i]);
    nob = (o.size() + 7) / 8;
    for (int k = 0; k < nob; k++) begin
      rem = o.size() - 8 * k;
      if (rem > 8) rem = 8;
      exp_keep.push_back(8'((1 << rem) - 1));
      exp_last.push_back(k == nob - 1);
      exp_tid.push_back(4'(tid));
      exp_dest.push_back(1'(dest));
    end
    nb = (len + 7) / 8;
    if (max_beats >= 0 && max_beats < nb) nb = max_beats;
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        while ($urandom_range(1) == 0) begin
          axis_in_tvalid = 1'b0;
          @(posedge aclk);
          #1;
        end
      end
      axis_in_tdata = '0;
      axis_in_tkeep = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * k + j < len) begin
          axis_in_tdata[8*j +: 8] = b[8*k + j];
          axis_in_tkeep[j] = 1'b1;
        end
      end
      axis_in_tid    = 4'(tid);
      axis_in_tdest  = 1'(dest);
      axis_in_tlast  = (k == (len + 7) / 8 - 1);
      axis_in_tvalid = 1'b1;
      fire  = 1'b0;
      guard = 0;
      while (!fire && guard < 2000) begin
        @(negedge aclk);
        fire = axis_in_tvalid && axis_in_tready;
        @(posedge aclk);
        #1;
        guard++;
      end
      if (!fire) begin
        n_cmp++; n_err++;
        $display("FAIL in_handshake: beat %0d tready=%b, want 1 within 2000 cycles", k, axis_in_tready);
        break;
      end
      if (flip && k == 0) cfg[tid][16] = ~cfg[tid][16];
    end
    axis_in_tvalid = 1'b0;
    if (flip) cfg[tid] = c;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int g = 0;
    while (mon_frames < n && g < 20000) begin
      @(posedge aclk);
      g++;
    end
    #1;
    ok = (mon_frames >= n);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    axis_in_tvalid = 1'b0;
    axis_in_tdata = '0;
    axis_in_tkeep = '0;
    axis_in_tlast = 1'b0;
    axis_in_tid = 4'hA;
    axis_in_tdest = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (axis_out_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", axis_out_tvalid); end
    n_cmp++; if (axis_out_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", axis_out_tlast); end
    n_cmp++; if (axis_out_tdata !== 64'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", axis_out_tdata); end
    n_cmp++; if (axis_out_tkeep !== 8'h0) begin n_err++; $display("FAIL reset_tkeep: got %h want 0", axis_out_tkeep); end
    n_cmp++; if (tagged_pkt_count !== 32'h0) begin n_err++; $display("FAIL reset_count: got %0d want 0", tagged_pkt_count); end
    n_cmp++; if (vlan_config_sel !== 4'hA) begin n_err++; $display("FAIL config_sel: got %h want a", vlan_config_sel); end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    n_cmp++; if (axis_in_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b want 1", axis_in_tready); end
  endtask

  task automatic test_passthrough();
    bit ok;
    int d;
    clear_all();
    cfg[2] = {1'b0, 16'h0123};
    send_frame(2, 1, 64, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pass_timeout: frames %0d want 1", mon_frames); end
    d = bytes_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL pass_bytes: first diff at %0d want -1", d); end
    n_cmp++; if (mon_keep.size() != 8) begin n_err++; $display("FAIL pass_beats: got %0d want 8", mon_keep.size()); end
    d = beats_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL pass_beatfields: first diff at %0d want -1", d); end
    n_cmp++; if (tagged_pkt_count !== 32'd0) begin n_err++; $display("FAIL pass_count: got %0d want 0", tagged_pkt_count); end
  endtask

  task automatic test_insert_64();
    bit ok;
    int d;
    logic [31:0] tag_bytes;
    clear_all();
    cfg[3] = {1'b1, 16'h6005};
    send_frame(3, 0, 64, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ins64_timeout: frames %0d want 1", mon_frames); end
    tag_bytes = (mon_bytes.size() >= 16) ?
                {mon_bytes[12], mon_bytes[13], mon_bytes[14], mon_bytes[15]} : 32'hX;
    n_cmp++; if (tag_bytes !== 32'h8100_6005) begin n_err++; $display("FAIL ins64_tag: got %h want 81006005", tag_bytes); end
    d = bytes_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL ins64_bytes: first diff at %0d want -1", d); end
    n_cmp++; if (mon_bytes.size() != 68) begin n_err++; $display("FAIL ins64_len: got %0d want 68", mon_bytes.size()); end
    n_cmp++; if (mon_keep.size() != 9) begin n_err++; $display("FAIL ins64_beats: got %0d want 9", mon_keep.size()); end
    n_cmp++; if (mon_keep.size() == 0 || mon_keep[mon_keep.size()-1] !== 8'h0F) begin
      n_err++; $display("FAIL ins64_lastkeep: got %h want 0f", (mon_keep.size() == 0) ? 8'hXX : mon_keep[mon_keep.size()-1]);
    end
    d = beats_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL ins64_beatfields: first diff at %0d want -1", d); end
    n_cmp++; if (tagged_pkt_count !== 32'd1) begin n_err++; $display("FAIL ins64_count: got %0d want 1", tagged_pkt_count); end
  endtask

  task automatic test_insert_60();
    bit ok;
    int d;
    clear_all();
    send_frame(3, 1, 60, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ins60_timeout: frames %0d want 1", mon_frames); end
    d = bytes_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL ins60_bytes: first diff at %0d want -1", d); end
    n_cmp++; if (mon_keep.size() != 8) begin n_err++; $display("FAIL ins60_beats: got %0d want 8", mon_keep.size()); end
    n_cmp++; if (mon_keep.size() == 0 || mon_keep[mon_keep.size()-1] !== 8'hFF) begin
      n_err++; $display("FAIL ins60_lastkeep: got %h want ff", (mon_keep.size() == 0) ? 8'hXX : mon_keep[mon_keep.size()-1]);
    end
    n_cmp++; if (tagged_pkt_count !== 32'd2) begin n_err++; $display("FAIL ins60_count: got %0d want 2", tagged_pkt_count); end
  endtask

  task automatic test_runts();
    bit ok;
    int d;
    logic [31:0] tag_bytes;
    cfg[5] = {1'b1, 16'hABCD};
    // 8-byte runt: single beat, untouched
    clear_all();
    send_frame(5, 0, 8, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    d = bytes_diff();
    n_cmp++; if (!ok || d != -1) begin n_err++; $display("FAIL runt8_bytes: diff at %0d frames %0d want -1/1", d, mon_frames); end
    n_cmp++; if (mon_keep.size() != 1) begin n_err++; $display("FAIL runt8_beats: got %0d want 1", mon_keep.size()); end
    n_cmp++; if (tagged_pkt_count !== 32'd2) begin n_err++; $display("FAIL runt8_count: got %0d want 2", tagged_pkt_count); end
    // 10-byte frame: too short for a tag
    clear_all();
    send_frame(5, 1, 10, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    d = bytes_diff();
    n_cmp++; if (!ok || d != -1) begin n_err++; $display("FAIL runt10_bytes: diff at %0d frames %0d want -1/1", d, mon_frames); end
    d = beats_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL runt10_beatfields: first diff at %0d want -1", d); end
    n_cmp++; if (tagged_pkt_count !== 32'd2) begin n_err++; $display("FAIL runt10_count: got %0d want 2", tagged_pkt_count); end
    // 12-byte frame: tag lands at the very end, tlast on beat 1
    clear_all();
    send_frame(5, 0, 12, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    tag_bytes = (mon_bytes.size() >= 16) ?
                {mon_bytes[12], mon_bytes[13], mon_bytes[14], mon_bytes[15]} : 32'hX;
    n_cmp++; if (tag_bytes !== 32'h8100_ABCD) begin n_err++; $display("FAIL runt12_tag: got %h want 8100abcd", tag_bytes); end
    d = bytes_diff();
    n_cmp++; if (!ok || d != -1) begin n_err++; $display("FAIL runt12_bytes: diff at %0d frames %0d want -1/1", d, mon_frames); end
    n_cmp++; if (mon_keep.size() != 2 || mon_last[mon_last.size()-1] !== 1'b1) begin
      n_err++; $display("FAIL runt12_beats: got %0d beats want 2 with tlast", mon_keep.size());
    end
    n_cmp++; if (tagged_pkt_count !== 32'd3) begin n_err++; $display("FAIL runt12_count: got %0d want 3", tagged_pkt_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d, len;
    int tids[4];
    tids[0] = 0; tids[1] = 6; tids[2] = 9; tids[3] = 15;
    cfg[0]  = {1'b1, 16'h0001};
    cfg[6]  = {1'b0, 16'h5555};
    cfg[9]  = {1'b1, 16'hE00F};
    cfg[15] = {1'b1, 16'h2FFF};
    clear_all();
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      len = 1 + ((i * 37 + 5) % 97);
      send_frame(tids[i % 4], i % 2, len, 1'b1, (i % 5) == 2, -1);
    end
    wait_frames(100, ok);
    rdy_mode = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: frames %0d want 100", mon_frames); end
    d = bytes_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL b2b_bytes: first diff at %0d want -1", d); end
    d = beats_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL b2b_beatfields: first diff at %0d want -1", d); end
    n_cmp++; if (tagged_pkt_count !== 32'(exp_tagged)) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", tagged_pkt_count, exp_tagged); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int d;
    cfg[1] = {1'b1, 16'h1234};
    clear_all();
    rdy_mode = 0;
    send_frame(1, 0, 40, 1'b0, 1'b0, 2);
    rdy_mode = 2;
    axis_out_tready = 1'b0;
    n_cmp++; if (axis_out_tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_tvalid: got %b want 1", axis_out_tvalid); end
    #2;
    aresetn = 1'b0;
    #1;
    n_cmp++; if (axis_out_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid: got %b want 0", axis_out_tvalid); end
    n_cmp++; if (tagged_pkt_count !== 32'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", tagged_pkt_count); end
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rdy_mode = 0;
    axis_out_tready = 1'b1;
    clear_all();
    exp_tagged = 0;
    @(posedge aclk);
    #1;
    send_frame(1, 1, 40, 1'b0, 1'b0, -1);
    wait_frames(1, ok);
    d = bytes_diff();
    n_cmp++; if (!ok || d != -1) begin n_err++; $display("FAIL rstmid_bytes: diff at %0d frames %0d want -1/1", d, mon_frames); end
    d = beats_diff();
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL rstmid_beatfields: first diff at %0d want -1", d); end
    n_cmp++; if (tagged_pkt_count !== 32'd1) begin n_err++; $display("FAIL rstmid_count2: got %0d want 1", tagged_pkt_count); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cfg[i] = '0;
    test_reset();
    test_passthrough();
    test_insert_64();
    test_insert_60();
    test_runts();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
